fifo_rptr_empty: RTL and testbench

Read-side pointer and empty logic for the router's asynchronous FIFO, with a first-word-fall-through output register. The block lives entirely in the read clock domain. It takes the write pointer (Gray code, already passed through a 2-DFF synchronizer) and produces a registered Gray-coded read pointer for synchronization back to the write side. It drives the binary read address to the dual-port storage and presents data to the consumer through a valid/ready handshake.

---
 rtl/fifo_rptr_empty.sv | 80 ++++++++
 tb/tb_fifo_rptr_empty.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer, empty detection and first-word-fall-through output register
// for the asynchronous FIFO; everything here runs on RCLK.
module fifo_rptr_empty #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int PTR_W  = ADDR_W + 1,
  parameter int DATA_W = 32
) (
  input  logic              RCLK,
  input  logic              RRST,
  input  logic [PTR_W-1:0]  RQ2_WPTR,
  input  logic [DATA_W-1:0] RMEM_DATA,
  input  logic              RFLUSH,
  input  logic              RREADY,
  output logic [PTR_W-1:0]  RPTR,
  output logic [ADDR_W-1:0] RADDR,
  output logic              REMPTY,
  output logic              RVALID,
  output logic [DATA_W-1:0] RDOUT,
  output logic [PTR_W-1:0]  RLEVEL
);

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_W-1:0]  rptrBin_q, rptrBin_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdout_q, rdout_d;
  logic [PTR_W-1:0]  wq2Bin;
  logic              pop;

  assign wq2Bin = gray2bin(RQ2_WPTR);
  assign REMPTY = (rptr_q == RQ2_WPTR);
  assign RLEVEL = wq2Bin - rptrBin_q;
  assign RADDR  = rptrBin_q[ADDR_W-1:0];
  assign RPTR   = rptr_q;
  assign RVALID = rvalid_q;
  assign RDOUT  = rdout_q;
  assign pop    = ~REMPTY & (~rvalid_q | RREADY);

  // Gray pointer is always derived from the next binary value so both registers stay in lockstep.
  always_comb begin
    rptrBin_d = rptrBin_q;
    rvalid_d  = rvalid_q;
    rdout_d   = rdout_q;
    if (RFLUSH) begin
      rptrBin_d = wq2Bin;
      rvalid_d  = 1'b0;
    end else if (pop) begin
      rptrBin_d = rptrBin_q + 1'b1;
      rdout_d   = RMEM_DATA;
      rvalid_d  = 1'b1;
    end else if (rvalid_q && RREADY) begin
      rvalid_d  = 1'b0;
    end
    rptr_d = rptrBin_d ^ (rptrBin_d >> 1);
  end

  always_ff @(posedge RCLK) begin
    if (RRST) begin
      rptrBin_q <= '0;
      rptr_q    <= '0;
      rvalid_q  <= 1'b0;
      rdout_q   <= '0;
    end else begin
      rptrBin_q <= rptrBin_d;
      rptr_q    <= rptr_d;
      rvalid_q  <= rvalid_d;
      rdout_q   <= rdout_d;
    end
  end

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Self-checking bench for fifo_rptr_empty: scoreboard of expected words plus
// directed checks of pointer, level and handshake state.
module tb_fifo_rptr_empty;

  logic        RCLK;
  logic        RRST;
  logic [4:0]  RQ2_WPTR;
  logic [31:0] RMEM_DATA;
  logic        RFLUSH;
  logic        RREADY;
  logic [4:0]  RPTR;
  logic [3:0]  RADDR;
  logic        REMPTY;
  logic        RVALID;
  logic [31:0] RDOUT;
  logic [4:0]  RLEVEL;

  logic [31:0] mem [16];
  logic [4:0]  wBin;
  logic [31:0] expQ [$];
  int          compared;
  int          mismatched;
  logic        checkGray;
  logic [4:0]  prevRptr;

  fifo_rptr_empty #(.DEPTH(16), .DATA_W(32)) dut (
    .RCLK(RCLK), .RRST(RRST), .RQ2_WPTR(RQ2_WPTR), .RMEM_DATA(RMEM_DATA),
    .RFLUSH(RFLUSH), .RREADY(RREADY), .RPTR(RPTR), .RADDR(RADDR),
    .REMPTY(REMPTY), .RVALID(RVALID), .RDOUT(RDOUT), .RLEVEL(RLEVEL)
  );

  assign RMEM_DATA = mem[RADDR];

  initial RCLK = 1'b0;
  always #5 RCLK = ~RCLK;

  function automatic logic [4:0] toGray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge RCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Writer model: store one word, queue it as expected, advance synchronized write pointer
  task automatic applyStimulus(input logic [31:0] data);
    mem[wBin[3:0]] = data;
    expQ.push_back(data);
    wBin = wBin + 5'd1;
    RQ2_WPTR = toGray(wBin);
  endtask

  task automatic doReset();
    RRST = 1'b1;
    RFLUSH = 1'b0;
    RREADY = 1'b0;
    wBin = '0;
    RQ2_WPTR = '0;
    expQ.delete();
    tick();
    tick();
    RRST = 1'b0;
  endtask

  // Monitor: a transfer happens at the next rising edge; compare word against scoreboard
  always @(negedge RCLK) begin
    if (!RRST && !RFLUSH && RVALID && RREADY) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_word: got %h, expected no word", RDOUT);
      end else begin
        checkOutput("rdout_order", RDOUT, expQ.pop_front());
      end
    end
    if (checkGray) begin
      checkOutput("rptr_one_bit_step", 32'($countones(RPTR ^ prevRptr) <= 1), 32'd1);
    end
    prevRptr = RPTR;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared = 0;
    mismatched = 0;
    checkGray = 1'b0;
    prevRptr = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    RRST = 1'b1;
    RFLUSH = 1'b0;
    RREADY = 1'b0;
    wBin = '0;
    RQ2_WPTR = '0;

    // Reset state
    doReset();
    checkOutput("reset_rptr", 32'(RPTR), 32'd0);
    checkOutput("reset_raddr", 32'(RADDR), 32'd0);
    checkOutput("reset_rempty", 32'(REMPTY), 32'd1);
    checkOutput("reset_rvalid", 32'(RVALID), 32'd0);
    checkOutput("reset_rlevel", 32'(RLEVEL), 32'd0);
    checkOutput("reset_rdout", RDOUT, 32'd0);
    RREADY = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("idle_ready_rptr", 32'(RPTR), 32'd0);
    checkOutput("idle_ready_rvalid", 32'(RVALID), 32'd0);

    // Single word fall-through
    RREADY = 1'b0;
    applyStimulus(32'hA5A5_A5A5);
    #1;
    checkOutput("single_rempty_low", 32'(REMPTY), 32'd0);
    checkOutput("single_rlevel_1", 32'(RLEVEL), 32'd1);
    tick();
    checkOutput("single_rvalid", 32'(RVALID), 32'd1);
    checkOutput("single_rdout", RDOUT, 32'hA5A5_A5A5);
    checkOutput("single_rptr", 32'(RPTR), 32'b00001);
    checkOutput("single_rempty", 32'(REMPTY), 32'd1);
    checkOutput("single_rlevel_0", 32'(RLEVEL), 32'd0);
    RREADY = 1'b1;
    tick();
    checkOutput("single_drained", 32'(RVALID), 32'd0);

    // Burst of 8 with RREADY held high: no bubbles
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(32'h1000_0000 + 32'(i));
    RREADY = 1'b1;
    #1;
    checkOutput("burst_rlevel_8", 32'(RLEVEL), 32'd8);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput("burst_rvalid", 32'(RVALID), 32'd1);
      checkOutput("burst_rlevel", 32'(RLEVEL), 32'(8 - k));
    end
    checkOutput("burst_rptr", 32'(RPTR), 32'b01100);
    checkOutput("burst_rempty", 32'(REMPTY), 32'd1);
    tick();
    checkOutput("burst_done", 32'(RVALID), 32'd0);

    // Backpressure: one word latched, pointer holds
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(32'h2000_0000 + 32'(i));
    tick();
    tick();
    tick();
    checkOutput("bp_rvalid", 32'(RVALID), 32'd1);
    checkOutput("bp_rdout", RDOUT, 32'h2000_0000);
    checkOutput("bp_rptr", 32'(RPTR), 32'b00001);
    checkOutput("bp_raddr", 32'(RADDR), 32'd1);
    checkOutput("bp_rlevel", 32'(RLEVEL), 32'd3);
    RREADY = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("bp_drained", 32'(RVALID), 32'd0);
    checkOutput("bp_rptr_end", 32'(RPTR), 32'b00110);

    // Wrap-around: 40 words streamed, one per cycle
    doReset();
    RREADY = 1'b1;
    #1;
    checkGray = 1'b1;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(32'h3000_0000 + 32'(n));
      tick();
      checkOutput("wrap_rptr", 32'(RPTR), 32'(toGray(5'(n + 1))));
      checkOutput("wrap_raddr", 32'(RADDR), 32'((n + 1) % 16));
    end
    tick();
    checkGray = 1'b0;
    checkOutput("wrap_drained", 32'(RVALID), 32'd0);
    checkOutput("wrap_rptr_end", 32'(RPTR), 32'b01100);

    // Flush mid-stream after 3 words consumed
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(32'h4000_0000 + 32'(i));
    RREADY = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("flush_consumed", 32'(expQ.size()), 32'd7);
    checkOutput("flush_pre_rdout", RDOUT, 32'h4000_0003);
    RFLUSH = 1'b1;
    expQ.delete();
    tick();
    RFLUSH = 1'b0;
    #1;
    checkOutput("flush_rvalid", 32'(RVALID), 32'd0);
    checkOutput("flush_rptr", 32'(RPTR), 32'b01111);
    checkOutput("flush_rempty", 32'(REMPTY), 32'd1);
    checkOutput("flush_rlevel", 32'(RLEVEL), 32'd0);
    checkOutput("flush_rdout_held", RDOUT, 32'h4000_0003);
    tick();
    checkOutput("flush_stays_idle", 32'(RVALID), 32'd0);

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
